// File: rtl/dbf_arb_pkg.sv
// Shared types and defaults for the delay-LUT arbiter: FSM encoding, LUT geometry, clog2 helper.
package dbf_arb_pkg;

    localparam int DEF_ADDR_WD = 12;
    localparam int DEF_DATA_WD = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dly_lut_arbiter_rr_arbiter.sv
// Masked round-robin picker; the pointer moves past the winner only when a grant is taken.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_WD   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_WD-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [ID_WD-1:0]   ptr_q;
    logic [ID_WD-1:0]   ptr_d;
    logic [NUM_REQ-1:0] elig;
    int                 cand;
    int                 nxt;

    assign elig = req & ~mask;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (en && !gnt_any && elig[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = ID_WD'(cand);
            end
        end
    end

    always_comb begin
        nxt   = int'(gnt_idx) + 1;
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (nxt >= NUM_REQ) ? '0 : ID_WD'(nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dly_lut_arbiter.sv
// Shares the single-port delay LUT between per-channel readers and the host write port.
// Optional saturating stall counters are built in when DLY_LUT_ARB_STATS_EN is defined.
module dly_lut_arbiter
    import dbf_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_WD = DEF_ADDR_WD,
    parameter int DATA_WD = DEF_DATA_WD,
    parameter int RD_LAT  = 1,
    parameter int ID_WD   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       line_active,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_WD-1:0] req_addr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rd_vld,
    output logic [ID_WD-1:0]           rd_id,
    output logic [DATA_WD-1:0]         rd_data,
    input  logic                       cfg_we,
    input  logic [ADDR_WD-1:0]         cfg_addr,
    input  logic [DATA_WD-1:0]         cfg_wdata,
    output logic                       cfg_ack,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_WD-1:0]         mem_addr,
    output logic [DATA_WD-1:0]         mem_wdata,
    input  logic [DATA_WD-1:0]         mem_rdata
`ifdef DLY_LUT_ARB_STATS_EN
   ,input  logic                       stats_clr
   ,output logic [15:0]                stall_cnt
   ,output logic [15:0]                wr_stall_cnt
`endif
);

    // states: IDLE no issue | READ read issued this cycle | WRITE host write issued this cycle
    arb_state_e         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               rd_vld_q;
    logic [ID_WD-1:0]   rd_id_q;
    logic [DATA_WD-1:0] rd_data_q;
    logic               cfg_ack_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [ADDR_WD-1:0] mem_addr_q;
    logic [DATA_WD-1:0] mem_wdata_q;
    logic [RD_LAT:0]    vld_pipe_q;
    logic [ID_WD-1:0]   id_pipe_q [RD_LAT+1];

    logic               can_decide;
    logic               wr_go;
    logic               rd_en;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [ID_WD-1:0]   rr_idx;
    logic               rr_any;

    assign can_decide = (state_q != ST_WRITE);
    assign wr_go      = can_decide && cfg_we && !line_active;
    assign rd_en      = can_decide && !wr_go;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WD   (ID_WD)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rd_en),
        .req     (req),
        .mask    (gnt_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            cfg_ack_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            gnt_q     <= rr_gnt;
            cfg_ack_q <= wr_go;
            mem_en_q  <= wr_go | rr_any;
            mem_we_q  <= wr_go;
            if (wr_go) begin
                state_q     <= ST_WRITE;
                mem_addr_q  <= cfg_addr;
                mem_wdata_q <= cfg_wdata;
            end else if (rr_any) begin
                state_q    <= ST_READ;
                mem_addr_q <= req_addr[int'(rr_idx)*ADDR_WD +: ADDR_WD];
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

    // Stage 0 lines up with mem_en; stage RD_LAT lines up with valid mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            for (int j = 0; j <= RD_LAT; j++) begin
                id_pipe_q[j] <= '0;
            end
            rd_vld_q  <= 1'b0;
            rd_id_q   <= '0;
            rd_data_q <= '0;
        end else begin
            vld_pipe_q   <= {vld_pipe_q[RD_LAT-1:0], rr_any};
            id_pipe_q[0] <= rr_idx;
            for (int j = 1; j <= RD_LAT; j++) begin
                id_pipe_q[j] <= id_pipe_q[j-1];
            end
            rd_vld_q <= vld_pipe_q[RD_LAT];
            if (vld_pipe_q[RD_LAT]) begin
                rd_id_q   <= id_pipe_q[RD_LAT];
                rd_data_q <= mem_rdata;
            end
        end
    end

    assign gnt       = gnt_q;
    assign rd_vld    = rd_vld_q;
    assign rd_id     = rd_id_q;
    assign rd_data   = rd_data_q;
    assign cfg_ack   = cfg_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef DLY_LUT_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] wr_stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q    <= '0;
            wr_stall_cnt_q <= '0;
        end else if (stats_clr) begin
            stall_cnt_q    <= '0;
            wr_stall_cnt_q <= '0;
        end else begin
            if ((|req) && !rr_any && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (cfg_we && line_active && (wr_stall_cnt_q != 16'hFFFF)) begin
                wr_stall_cnt_q <= wr_stall_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign wr_stall_cnt = wr_stall_cnt_q;
`endif

endmodule

// File: tb/tb_dly_lut_arbiter.sv
// Directed bench for dly_lut_arbiter with a 1-cycle-latency LUT RAM model.
module tb_dly_lut_arbiter;

    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 16;

    logic             clk;
    logic             rst_n;
    logic             line_active;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    gnt;
    logic             rd_vld;
    logic [1:0]       rd_id;
    logic [DW-1:0]    rd_data;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [DW-1:0]    cfg_wdata;
    logic             cfg_ack;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
`ifdef DLY_LUT_ARB_STATS_EN
    logic             stats_clr;
    logic [15:0]      stall_cnt;
    logic [15:0]      wr_stall_cnt;
`endif

    logic [DW-1:0]    ram [1 << AW];
    int               n_assert;
    int               n_fail;

    dly_lut_arbiter #(
        .NUM_REQ (NR),
        .ADDR_WD (AW),
        .DATA_WD (DW),
        .RD_LAT  (1),
        .ID_WD   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_active  (line_active),
        .req          (req),
        .req_addr     (req_addr),
        .gnt          (gnt),
        .rd_vld       (rd_vld),
        .rd_id        (rd_id),
        .rd_data      (rd_data),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_ack      (cfg_ack),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
`ifdef DLY_LUT_ARB_STATS_EN
       ,.stats_clr    (stats_clr)
       ,.stall_cnt    (stall_cnt)
       ,.wr_stall_cnt (wr_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [DW-1:0] lut(input logic [AW-1:0] a);
        return DW'(a) * 16'd3 + 16'h1000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int idx, input logic [AW-1:0] a);
        req_addr[idx*AW +: AW] = a;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          order [5];
        logic [AW-1:0] rr_addr [4];
        n_assert = 0;
        n_fail   = 0;
        order    = '{0, 1, 2, 3, 0};
        rr_addr  = '{12'h100, 12'h201, 12'h302, 12'h403};
        for (int a = 0; a < (1 << AW); a++) ram[a] = lut(AW'(a));
        mem_rdata   = '0;
        rst_n       = 1'b0;
        line_active = 1'b0;
        req         = '0;
        req_addr    = '0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_wdata   = '0;
`ifdef DLY_LUT_ARB_STATS_EN
        stats_clr   = 1'b0;
`endif

        // Reset state
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rd_vld", 32'(rd_vld), 0);
        chk("rst_cfg_ack", 32'(cfg_ack), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        rst_n = 1'b1;
        step();

        // Round-robin fairness with all four requesters held
        for (int i = 0; i < NR; i++) set_addr(i, rr_addr[i]);
        line_active = 1'b1;
        req         = 4'b1111;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (s <= 5) begin
                chk($sformatf("rr_gnt_s%0d", s), 32'(gnt), 32'(1 << order[s-1]));
                chk($sformatf("rr_mem_addr_s%0d", s), 32'(mem_addr), 32'(rr_addr[order[s-1]]));
                chk($sformatf("rr_mem_we_s%0d", s), 32'(mem_we), 0);
            end else begin
                chk($sformatf("rr_gnt_s%0d", s), 32'(gnt), 0);
            end
            if (s >= 3 && s <= 7) begin
                chk($sformatf("rr_rd_vld_s%0d", s), 32'(rd_vld), 1);
                chk($sformatf("rr_rd_id_s%0d", s), 32'(rd_id), 32'(order[s-3]));
                chk($sformatf("rr_rd_data_s%0d", s), 32'(rd_data), 32'(lut(rr_addr[order[s-3]])));
            end else begin
                chk($sformatf("rr_rd_vld_s%0d", s), 32'(rd_vld), 0);
            end
            if (s == 5) req = '0;
        end

        // Single requester: one grant every second cycle
        set_addr(2, 12'h0A5);
        req = 4'b0100;
        for (int s = 1; s <= 8; s++) begin
            step();
            chk($sformatf("single_gnt_s%0d", s), 32'(gnt), (s % 2 == 1) ? 32'h4 : 32'h0);
            chk($sformatf("single_rd_vld_s%0d", s), 32'(rd_vld), (s >= 3 && s % 2 == 1) ? 1 : 0);
            if (s == 3) begin
                chk("single_rd_id", 32'(rd_id), 2);
                chk("single_rd_data", 32'(rd_data), 32'(lut(12'h0A5)));
            end
        end
        req = '0;
        step();
        step();
        step();

        // Write stalls while the line is active
        line_active = 1'b1;
        cfg_we      = 1'b1;
        cfg_addr    = 12'h040;
        cfg_wdata   = 16'h1234;
        for (int s = 1; s <= 10; s++) begin
            step();
            chk($sformatf("wstall_ack_s%0d", s), 32'(cfg_ack), 0);
            chk($sformatf("wstall_mem_en_s%0d", s), 32'(mem_en), 0);
        end
        line_active = 1'b0;
        step();
        chk("wr_ack", 32'(cfg_ack), 1);
        chk("wr_mem_en", 32'(mem_en), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h040);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
        chk("wr_no_gnt", 32'(gnt), 0);
        cfg_we = 1'b0;
        step();
        chk("wr_ack_drop", 32'(cfg_ack), 0);
        chk("wr_idle_mem_en", 32'(mem_en), 0);
        chk("wr_idle_mem_we", 32'(mem_we), 0);
        chk("wr_addr_hold", 32'(mem_addr), 32'h040);

        // Read back the written word
        line_active = 1'b1;
        set_addr(1, 12'h040);
        req = 4'b0010;
        step();
        chk("rdbk_gnt", 32'(gnt), 32'h2);
        req = '0;
        step();
        step();
        chk("rdbk_rd_vld", 32'(rd_vld), 1);
        chk("rdbk_rd_id", 32'(rd_id), 1);
        chk("rdbk_rd_data", 32'(rd_data), 32'h1234);
        step();

        // Write wins over simultaneous reads; pointer (at 2) untouched
        line_active = 1'b0;
        set_addr(0, 12'h100);
        set_addr(1, 12'h201);
        req       = 4'b0011;
        cfg_we    = 1'b1;
        cfg_addr  = 12'h050;
        cfg_wdata = 16'hBEEF;
        step();
        chk("prio_ack", 32'(cfg_ack), 1);
        chk("prio_no_gnt", 32'(gnt), 0);
        chk("prio_mem_addr", 32'(mem_addr), 32'h050);
        cfg_we = 1'b0;
        step();
        chk("prio_gap_gnt", 32'(gnt), 0);
        chk("prio_gap_ack", 32'(cfg_ack), 0);
        step();
        chk("prio_gnt_a", 32'(gnt), 32'h1);
        chk("prio_mem_addr_a", 32'(mem_addr), 32'h100);
        step();
        chk("prio_gnt_b", 32'(gnt), 32'h2);
        req = '0;
        step();
        step();
        step();

        // Reset with two reads in flight
        line_active = 1'b1;
        set_addr(2, 12'h302);
        req = 4'b0110;
        step();
        chk("mid_gnt_a", 32'(gnt), 32'h4);
        step();
        chk("mid_gnt_b", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_mem_en", 32'(mem_en), 0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 0);
        chk("mid_rst_rd_vld", 32'(rd_vld), 0);
        chk("mid_rst_rd_data", 32'(rd_data), 0);
        step();
        step();
        rst_n = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            step();
            chk($sformatf("post_rst_rd_vld_s%0d", s), 32'(rd_vld), 0);
        end
        req = 4'b0111;
        step();
        chk("post_rst_first_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();
        step();
        step();

`ifdef DLY_LUT_ARB_STATS_EN
        line_active = 1'b1;
        cfg_we      = 1'b1;
        for (int s = 1; s <= 5; s++) step();
        cfg_we = 1'b0;
        chk("stats_wr_stall", 32'(wr_stall_cnt), 5);
        step();
        chk("stats_wr_stall_hold", 32'(wr_stall_cnt), 5);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("stats_clr_wr", 32'(wr_stall_cnt), 0);
        chk("stats_clr_stall", 32'(stall_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
